mem_long_bank: RTL and testbench

//  Parametrised bank of recirculating drum long lines. It generalises the fixed
//  12-line long-line block to NUM_LINES lines of WORDS x WORD_BITS bits each,

---
 rtl/mem_long_bank.sv | 146 ++++++++++++++
 tb/tb_mem_long_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_long_bank.sv
// rtl/mem_long_bank.sv - parametrised bank of recirculating drum long lines with host word port
module mem_long_bank #(
  parameter int NUM_LINES = 12,
  parameter int WORDS     = 108,
  parameter int WORD_BITS = 29,
  localparam int LINE_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 d_en,
  input  logic [LINE_W-1:0]    d_line,
  input  logic                 d_data,
  input  logic                 s_en,
  input  logic [LINE_W-1:0]    s_line,
  input  logic [NUM_LINES-1:0] clr_mask,
  output logic                 eb,
  output logic [4:0]           bit_time,
  output logic [6:0]           word_time,
  output logic                 word_start,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [LINE_W-1:0]    host_line,
  input  logic [6:0]           host_word,
  input  logic [WORD_BITS-1:0] host_wdata,
  output logic                 host_busy,
  output logic                 host_ack,
  output logic                 host_err,
  output logic [WORD_BITS-1:0] host_rdata
);
  localparam int N  = WORDS * WORD_BITS;
  localparam int KW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;
  state_t state, state_nxt;

  logic [N-1:0]           track [NUM_LINES];
  logic [NUM_LINES-1:0]   dout;
  logic [NUM_LINES-1:0]   din;

  logic                   lat_we;
  logic                   lat_err;
  logic [LINE_W-1:0]      lat_line;
  logic [6:0]             lat_word;
  logic [WORD_BITS-1:0]   lat_wdata;
  logic [WORD_BITS-1:0]   rbuf;
  logic [WORD_BITS-1:0]   rbuf_nxt;
  logic [KW-1:0]          k;
  logic [KW-1:0]          k_now;
  logic                   match;
  logic                   xfer_now;
  logic                   xfer_last;
  logic                   host_dout;
  logic                   req_bad;

  // Each track is a pure N-bit delay; the bit leaving track[i][0] is the one now at the head.
  always_ff @(posedge CLOCK) begin
    for (int i = 0; i < NUM_LINES; i++) begin
      track[i] <= {din[i], track[i][N-1:1]};
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      dout[i] = track[i][0];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      bit_time  <= 5'd0;
      word_time <= 7'd0;
    end else if (bit_time == 5'(WORD_BITS - 1)) begin
      bit_time  <= 5'd0;
      word_time <= (word_time == 7'(WORDS - 1)) ? 7'd0 : word_time + 7'd1;
    end else begin
      bit_time  <= bit_time + 5'd1;
    end
  end

  assign word_start = (bit_time == 5'd0);

  // The first transfer bit happens in the WAIT cycle that sees the word start,
  // so the word is moved in one pass with bit k aligned to bit_time k.
  assign match     = (word_time == lat_word) && (bit_time == 5'd0);
  assign xfer_now  = (state == S_XFER) || ((state == S_WAIT) && match);
  assign k_now     = (state == S_XFER) ? k : '0;
  assign xfer_last = (k_now == KW'(WORD_BITS - 1));
  assign req_bad   = ({1'b0, host_line} >= (LINE_W + 1)'(NUM_LINES)) ||
                     ({1'b0, host_word} >= 8'(WORDS));
  assign rbuf_nxt  = WORD_BITS'({host_dout, rbuf} >> 1);

  always_comb begin
    eb        = 1'b0;
    host_dout = 1'b0;
    din       = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      din[i] = dout[i];
      if (clr_mask[i]) din[i] = 1'b0;
      if (d_en && (d_line == LINE_W'(i))) din[i] = d_data;
      if (xfer_now && lat_we && (lat_line == LINE_W'(i))) din[i] = lat_wdata[k_now];
      if (s_en && (s_line == LINE_W'(i))) eb = dout[i];
      if (lat_line == LINE_W'(i)) host_dout = dout[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (host_req) state_nxt = req_bad ? S_DONE : S_WAIT;
      S_WAIT:  if (match) state_nxt = xfer_last ? S_DONE : S_XFER;
      S_XFER:  if (xfer_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign host_busy = (state != S_IDLE);
  assign host_ack  = (state == S_DONE);
  assign host_err  = host_ack && lat_err;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      k          <= '0;
      lat_err    <= 1'b0;
      host_rdata <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && host_req) begin
        lat_we    <= host_we;
        lat_line  <= host_line;
        lat_word  <= host_word;
        lat_wdata <= host_wdata;
        lat_err   <= req_bad;
      end
      if (xfer_now) begin
        k <= k_now + 1'b1;
        // Read bits arrive LSB first and are shifted in from the top.
        if (!lat_we) begin
          rbuf <= rbuf_nxt;
          if (xfer_last) host_rdata <= rbuf_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_long_bank.sv
// tb/tb_mem_long_bank.sv - randomized bench for mem_long_bank against a word-level drum model
module tb_mem_long_bank;
  localparam int NL  = 12;
  localparam int WDS = 108;
  localparam int WB  = 29;
  localparam int N   = WDS * WB;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          d_en;
  logic [3:0]    d_line;
  logic          d_data;
  logic          s_en;
  logic [3:0]    s_line;
  logic [NL-1:0] clr_mask;
  logic          eb;
  logic [4:0]    bit_time;
  logic [6:0]    word_time;
  logic          word_start;
  logic          host_req;
  logic          host_we;
  logic [3:0]    host_line;
  logic [6:0]    host_word;
  logic [WB-1:0] host_wdata;
  logic          host_busy;
  logic          host_ack;
  logic          host_err;
  logic [WB-1:0] host_rdata;

  mem_long_bank dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .d_en(d_en), .d_line(d_line), .d_data(d_data),
    .s_en(s_en), .s_line(s_line), .clr_mask(clr_mask),
    .eb(eb), .bit_time(bit_time), .word_time(word_time), .word_start(word_start),
    .host_req(host_req), .host_we(host_we), .host_line(host_line),
    .host_word(host_word), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_ack(host_ack), .host_err(host_err),
    .host_rdata(host_rdata)
  );

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int eb_ones = 0;

  // Word-level picture of the drum: mem[line][word] bit b is what appears at
  // the head when the timing counters read (word, b).
  logic [WB-1:0] mem [NL][WDS];

  bit            h_act = 1'b0;
  bit            h_we, h_err;
  int            h_line, h_word, h_req, h_start, h_ack;
  logic [WB-1:0] h_wdata, h_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    int pos, w, b;
    bit exp_eb, hwin;
    @(negedge CLOCK);
    pos = cyc % N;
    w = pos / WB;
    b = pos % WB;
    check_eq("bit_time", 32'(bit_time), 32'(b));
    check_eq("word_time", 32'(word_time), 32'(w));
    check_eq("word_start", 32'(word_start), 32'(b == 0));
    exp_eb = 1'b0;
    if (s_en && (s_line < NL)) exp_eb = mem[s_line][w][b];
    check_eq("eb", 32'(eb), 32'(exp_eb));
    if (eb) eb_ones++;
    check_eq("host_busy", 32'(host_busy), 32'(h_act && (cyc > h_req) && (cyc <= h_ack)));
    check_eq("host_ack", 32'(host_ack), 32'(h_act && (cyc == h_ack)));
    if (h_act && (cyc == h_ack)) begin
      check_eq("host_err", 32'(host_err), 32'(h_err));
      if (!h_we && !h_err) check_eq("host_rdata", 32'(host_rdata), 32'(h_rd));
    end
    hwin = h_act && !h_err && (cyc >= h_start) && (cyc < h_start + WB);
    if (hwin && !h_we) h_rd[cyc - h_start] = mem[h_line][w][b];
    for (int i = 0; i < NL; i++) begin
      if (hwin && h_we && (i == h_line)) mem[i][w][b] = h_wdata[cyc - h_start];
      else if (d_en && (d_line == i))    mem[i][w][b] = d_data;
      else if (clr_mask[i])              mem[i][w][b] = 1'b0;
    end
    @(posedge CLOCK);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    d_en = 1'b0; d_line = 4'd0; d_data = 1'b0;
    s_en = 1'b0; s_line = 4'd0; clr_mask = '0;
  endtask

  task automatic drive_rand();
    d_en     = ($urandom_range(0, 3) == 0);
    d_line   = 4'($urandom_range(0, 15));
    d_data   = 1'($urandom);
    s_en     = 1'($urandom);
    s_line   = 4'($urandom_range(0, 15));
    clr_mask = ($urandom_range(0, 15) == 0) ? NL'($urandom) : '0;
  endtask

  task automatic host_issue(input bit we, input int line, input int word,
                            input logic [WB-1:0] wd, input bit bg);
    int t;
    host_req = 1'b1; host_we = we;
    host_line = 4'(line); host_word = 7'(word); host_wdata = wd;
    h_act = 1'b1; h_we = we; h_line = line; h_word = word; h_wdata = wd;
    h_rd = '0; h_req = cyc;
    h_err = (line >= NL) || (word >= WDS);
    if (h_err) begin
      h_start = -1000;
      h_ack   = cyc + 1;
    end else begin
      t = cyc + 1;
      while ((t % N) != word * WB) t++;
      h_start = t;
      h_ack   = t + WB;
    end
    if (bg) drive_rand();
    tick();
    host_req = 1'b0;
    host_we = 1'($urandom); host_wdata = WB'($urandom);
    host_line = 4'($urandom); host_word = 7'($urandom);
  endtask

  task automatic host_op(input bit we, input int line, input int word,
                         input logic [WB-1:0] wd, input bit bg);
    host_issue(we, line, word, wd, bg);
    while (cyc <= h_ack) begin
      if (bg) drive_rand();
      tick();
    end
  endtask

  initial begin
    logic [WB-1:0] wd;
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < WDS; j++) mem[i][j] = '0;
    RESET = 1'b1; host_req = 1'b0; host_we = 1'b0; host_line = '0;
    host_word = '0; host_wdata = '0;
    drive_idle();
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    cyc = 0;
    check_eq("rst_rdata", 32'(host_rdata), 32'd0);
    check_eq("rst_err", 32'(host_err), 32'd0);
    check_eq("rst_busy", 32'(host_busy), 32'd0);
    check_eq("rst_bit_time", 32'(bit_time), 32'd0);

    // Clear every line so the model and the tracks start identical.
    clr_mask = '1;
    repeat (N) tick();
    clr_mask = '0;

    while ((cyc % N) != 5 * WB) tick();
    d_en = 1'b1; d_line = 4'd3; d_data = 1'b1;
    tick();
    d_en = 1'b0; s_en = 1'b1; s_line = 4'd3;
    eb_ones = 0;
    repeat (N) tick();
    check_eq("eb_ones_line3", 32'(eb_ones), 32'd1);

    repeat (2 * N) begin
      drive_rand();
      tick();
    end

    drive_idle();
    clr_mask = NL'(1 << 7);
    repeat (N) begin
      s_en = 1'b1;
      s_line = 4'($urandom_range(0, NL - 1));
      tick();
    end
    clr_mask = '0; s_line = 4'd7;
    eb_ones = 0;
    repeat (N) tick();
    check_eq("eb_ones_line7", 32'(eb_ones), 32'd0);

    drive_idle();
    host_op(1'b1, 11, 107, 29'h1ABCDEF0, 1'b0);
    host_op(1'b0, 11, 107, '0, 1'b0);
    check_eq("rd_l11_w107", 32'(host_rdata), 32'h1ABCDEF0);

    host_op(1'b1, 12, 3, 29'h0F0F0F0F, 1'b0);
    host_op(1'b1, 2, 108, 29'h0F0F0F0F, 1'b0);

    wd = WB'($urandom);
    d_en = 1'b1; d_line = 4'd2; d_data = 1'b0;
    host_op(1'b1, 2, 0, wd, 1'b0);
    drive_idle();
    host_op(1'b0, 2, 0, '0, 1'b0);
    check_eq("race_line2", 32'(host_rdata), 32'(wd));

    wd = WB'($urandom);
    d_en = 1'b1; d_line = 4'd5; d_data = 1'b1;
    host_op(1'b1, 4, 50, wd, 1'b0);
    drive_idle();
    host_op(1'b0, 4, 50, '0, 1'b0);
    check_eq("race_line4", 32'(host_rdata), 32'(wd));
    host_op(1'b0, 5, 50, '0, 1'b0);
    check_eq("race_line5", 32'(host_rdata), 32'h1FFFFFFF);

    repeat (3) begin
      host_op(1'($urandom), $urandom_range(0, NL - 1), $urandom_range(0, WDS - 1),
              WB'($urandom), 1'b1);
    end

    drive_idle();
    host_issue(1'b1, 0, 3, WB'($urandom), 1'b0);
    while (cyc < h_start + 10) tick();
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    cyc = 0;
    h_act = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
